// File: rtl/br_amba_axi_outstanding_limiter_pkg.sv
// Shared AXI field widths for the outstanding limiter and its counter.
package br_amba_axi_outstanding_limiter_pkg;

  localparam int AxiBurstLenWidth  = 8;
  localparam int AxiBurstSizeWidth = 3;
  localparam int AxiBurstTypeWidth = 2;
  localparam int AxiProtWidth      = 3;
  localparam int AxiRespWidth      = 2;

endpackage

// File: rtl/br_amba_axi_outstanding_counter.sv
// Saturating up/down transaction counter; flags a decrement seen while empty.
module br_amba_axi_outstanding_counter #(
  parameter int MaxCount = 4,
  localparam int CountWidth = $clog2(MaxCount + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  dec,
  output logic [CountWidth-1:0] count,
  output logic                  full,
  output logic                  underflow
);

  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;

  assign full      = (count_q == CountWidth'(MaxCount));
  assign underflow = dec & (count_q == '0);
  assign count     = count_q;

  // Simultaneous inc and dec cancel; a dec at zero never wraps.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + CountWidth'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CountWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/br_amba_axi_outstanding_limiter.sv
// AXI4 stage capping in-flight writes and reads by stalling AW/AR; W, B and R pass straight through.
// Optional sticky unexpected-response flag enabled by BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN.
module br_amba_axi_outstanding_limiter
  import br_amba_axi_outstanding_limiter_pkg::*;
#(
  parameter int AddrWidth           = 12,
  parameter int DataWidth           = 32,
  parameter int IdWidth             = 1,
  parameter int AWUserWidth         = 1,
  parameter int WUserWidth          = 1,
  parameter int ARUserWidth         = 1,
  parameter int BUserWidth          = 1,
  parameter int RUserWidth          = 1,
  parameter int MaxWriteOutstanding = 4,
  parameter int MaxReadOutstanding  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [AddrWidth-1:0]         target_awaddr,
  input  logic [IdWidth-1:0]           target_awid,
  input  logic [AxiBurstLenWidth-1:0]  target_awlen,
  input  logic [AxiBurstSizeWidth-1:0] target_awsize,
  input  logic [AxiBurstTypeWidth-1:0] target_awburst,
  input  logic [AxiProtWidth-1:0]      target_awprot,
  input  logic [AWUserWidth-1:0]       target_awuser,
  input  logic                         target_awvalid,
  output logic                         target_awready,
  output logic [AddrWidth-1:0]         init_awaddr,
  output logic [IdWidth-1:0]           init_awid,
  output logic [AxiBurstLenWidth-1:0]  init_awlen,
  output logic [AxiBurstSizeWidth-1:0] init_awsize,
  output logic [AxiBurstTypeWidth-1:0] init_awburst,
  output logic [AxiProtWidth-1:0]      init_awprot,
  output logic [AWUserWidth-1:0]       init_awuser,
  output logic                         init_awvalid,
  input  logic                         init_awready,

  input  logic [DataWidth-1:0]         target_wdata,
  input  logic [DataWidth/8-1:0]       target_wstrb,
  input  logic [WUserWidth-1:0]        target_wuser,
  input  logic                         target_wlast,
  input  logic                         target_wvalid,
  output logic                         target_wready,
  output logic [DataWidth-1:0]         init_wdata,
  output logic [DataWidth/8-1:0]       init_wstrb,
  output logic [WUserWidth-1:0]        init_wuser,
  output logic                         init_wlast,
  output logic                         init_wvalid,
  input  logic                         init_wready,

  input  logic [IdWidth-1:0]           init_bid,
  input  logic [BUserWidth-1:0]        init_buser,
  input  logic [AxiRespWidth-1:0]      init_bresp,
  input  logic                         init_bvalid,
  output logic                         init_bready,
  output logic [IdWidth-1:0]           target_bid,
  output logic [BUserWidth-1:0]        target_buser,
  output logic [AxiRespWidth-1:0]      target_bresp,
  output logic                         target_bvalid,
  input  logic                         target_bready,

  input  logic [AddrWidth-1:0]         target_araddr,
  input  logic [IdWidth-1:0]           target_arid,
  input  logic [AxiBurstLenWidth-1:0]  target_arlen,
  input  logic [AxiBurstSizeWidth-1:0] target_arsize,
  input  logic [AxiBurstTypeWidth-1:0] target_arburst,
  input  logic [AxiProtWidth-1:0]      target_arprot,
  input  logic [ARUserWidth-1:0]       target_aruser,
  input  logic                         target_arvalid,
  output logic                         target_arready,
  output logic [AddrWidth-1:0]         init_araddr,
  output logic [IdWidth-1:0]           init_arid,
  output logic [AxiBurstLenWidth-1:0]  init_arlen,
  output logic [AxiBurstSizeWidth-1:0] init_arsize,
  output logic [AxiBurstTypeWidth-1:0] init_arburst,
  output logic [AxiProtWidth-1:0]      init_arprot,
  output logic [ARUserWidth-1:0]       init_aruser,
  output logic                         init_arvalid,
  input  logic                         init_arready,

  input  logic [IdWidth-1:0]           init_rid,
  input  logic [DataWidth-1:0]         init_rdata,
  input  logic [RUserWidth-1:0]        init_ruser,
  input  logic [AxiRespWidth-1:0]      init_rresp,
  input  logic                         init_rlast,
  input  logic                         init_rvalid,
  output logic                         init_rready,
  output logic [IdWidth-1:0]           target_rid,
  output logic [DataWidth-1:0]         target_rdata,
  output logic [RUserWidth-1:0]        target_ruser,
  output logic [AxiRespWidth-1:0]      target_rresp,
  output logic                         target_rlast,
  output logic                         target_rvalid,
  input  logic                         target_rready,

  output logic [$clog2(MaxWriteOutstanding+1)-1:0] wr_outstanding,
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
  output logic                         err_unexpected_resp,
`endif
  output logic [$clog2(MaxReadOutstanding+1)-1:0]  rd_outstanding
);

  if (MaxWriteOutstanding < 1) begin : gen_chk_wr
    $error("MaxWriteOutstanding must be >= 1");
  end
  if (MaxReadOutstanding < 1) begin : gen_chk_rd
    $error("MaxReadOutstanding must be >= 1");
  end
  if (AddrWidth < 12) begin : gen_chk_addr
    $error("AddrWidth must be >= 12");
  end
  if (!(DataWidth == 32 || DataWidth == 64 || DataWidth == 128)) begin : gen_chk_data
    $error("DataWidth must be 32, 64 or 128");
  end

  logic wr_full, rd_full;
  logic wr_inc, wr_dec, rd_inc, rd_dec;

  assign init_awaddr  = target_awaddr;
  assign init_awid    = target_awid;
  assign init_awlen   = target_awlen;
  assign init_awsize  = target_awsize;
  assign init_awburst = target_awburst;
  assign init_awprot  = target_awprot;
  assign init_awuser  = target_awuser;
  assign init_awvalid   = target_awvalid & ~wr_full;
  assign target_awready = init_awready & ~wr_full;

  assign init_araddr  = target_araddr;
  assign init_arid    = target_arid;
  assign init_arlen   = target_arlen;
  assign init_arsize  = target_arsize;
  assign init_arburst = target_arburst;
  assign init_arprot  = target_arprot;
  assign init_aruser  = target_aruser;
  assign init_arvalid   = target_arvalid & ~rd_full;
  assign target_arready = init_arready & ~rd_full;

  assign init_wdata    = target_wdata;
  assign init_wstrb    = target_wstrb;
  assign init_wuser    = target_wuser;
  assign init_wlast    = target_wlast;
  assign init_wvalid   = target_wvalid;
  assign target_wready = init_wready;

  assign target_bid    = init_bid;
  assign target_buser  = init_buser;
  assign target_bresp  = init_bresp;
  assign target_bvalid = init_bvalid;
  assign init_bready   = target_bready;

  assign target_rid    = init_rid;
  assign target_rdata  = init_rdata;
  assign target_ruser  = init_ruser;
  assign target_rresp  = init_rresp;
  assign target_rlast  = init_rlast;
  assign target_rvalid = init_rvalid;
  assign init_rready   = target_rready;

  // Only the final R beat retires a read; every B retires a write.
  assign wr_inc = init_awvalid & init_awready;
  assign wr_dec = target_bvalid & target_bready;
  assign rd_inc = init_arvalid & init_arready;
  assign rd_dec = target_rvalid & target_rready & target_rlast;

`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
  logic wr_underflow, rd_underflow;
  logic err_q, err_d;

  assign err_d = err_q | wr_underflow | rd_underflow;
  assign err_unexpected_resp = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  br_amba_axi_outstanding_counter #(.MaxCount(MaxWriteOutstanding)) u_wr_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (wr_inc),
    .dec       (wr_dec),
    .count     (wr_outstanding),
    .full      (wr_full),
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    .underflow (wr_underflow)
`else
    .underflow ()
`endif
  );

  br_amba_axi_outstanding_counter #(.MaxCount(MaxReadOutstanding)) u_rd_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (rd_inc),
    .dec       (rd_dec),
    .count     (rd_outstanding),
    .full      (rd_full),
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    .underflow (rd_underflow)
`else
    .underflow ()
`endif
  );

endmodule

// File: tb/tb_br_amba_axi_outstanding_limiter.sv
// Directed self-checking bench for br_amba_axi_outstanding_limiter (default parameters).
module tb_br_amba_axi_outstanding_limiter;

  logic        clk;
  logic        rst_n;

  logic [11:0] target_awaddr, init_awaddr, target_araddr, init_araddr;
  logic        target_awid, init_awid, target_arid, init_arid;
  logic [7:0]  target_awlen, init_awlen, target_arlen, init_arlen;
  logic [2:0]  target_awsize, init_awsize, target_arsize, init_arsize;
  logic [1:0]  target_awburst, init_awburst, target_arburst, init_arburst;
  logic [2:0]  target_awprot, init_awprot, target_arprot, init_arprot;
  logic        target_awuser, init_awuser, target_aruser, init_aruser;
  logic        target_awvalid, target_awready, init_awvalid, init_awready;
  logic        target_arvalid, target_arready, init_arvalid, init_arready;

  logic [31:0] target_wdata, init_wdata;
  logic [3:0]  target_wstrb, init_wstrb;
  logic        target_wuser, init_wuser, target_wlast, init_wlast;
  logic        target_wvalid, target_wready, init_wvalid, init_wready;

  logic        init_bid, target_bid, init_buser, target_buser;
  logic [1:0]  init_bresp, target_bresp;
  logic        init_bvalid, init_bready, target_bvalid, target_bready;

  logic        init_rid, target_rid, init_ruser, target_ruser;
  logic [31:0] init_rdata, target_rdata;
  logic [1:0]  init_rresp, target_rresp;
  logic        init_rlast, target_rlast;
  logic        init_rvalid, init_rready, target_rvalid, target_rready;

  logic [2:0]  wr_outstanding, rd_outstanding;
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
  logic        err_unexpected_resp;
`endif

  int passCount = 0;
  int checkCount = 0;

  br_amba_axi_outstanding_limiter dut (
    .clk(clk), .rst_n(rst_n),
    .target_awaddr(target_awaddr), .target_awid(target_awid), .target_awlen(target_awlen),
    .target_awsize(target_awsize), .target_awburst(target_awburst), .target_awprot(target_awprot),
    .target_awuser(target_awuser), .target_awvalid(target_awvalid), .target_awready(target_awready),
    .init_awaddr(init_awaddr), .init_awid(init_awid), .init_awlen(init_awlen),
    .init_awsize(init_awsize), .init_awburst(init_awburst), .init_awprot(init_awprot),
    .init_awuser(init_awuser), .init_awvalid(init_awvalid), .init_awready(init_awready),
    .target_wdata(target_wdata), .target_wstrb(target_wstrb), .target_wuser(target_wuser),
    .target_wlast(target_wlast), .target_wvalid(target_wvalid), .target_wready(target_wready),
    .init_wdata(init_wdata), .init_wstrb(init_wstrb), .init_wuser(init_wuser),
    .init_wlast(init_wlast), .init_wvalid(init_wvalid), .init_wready(init_wready),
    .init_bid(init_bid), .init_buser(init_buser), .init_bresp(init_bresp),
    .init_bvalid(init_bvalid), .init_bready(init_bready),
    .target_bid(target_bid), .target_buser(target_buser), .target_bresp(target_bresp),
    .target_bvalid(target_bvalid), .target_bready(target_bready),
    .target_araddr(target_araddr), .target_arid(target_arid), .target_arlen(target_arlen),
    .target_arsize(target_arsize), .target_arburst(target_arburst), .target_arprot(target_arprot),
    .target_aruser(target_aruser), .target_arvalid(target_arvalid), .target_arready(target_arready),
    .init_araddr(init_araddr), .init_arid(init_arid), .init_arlen(init_arlen),
    .init_arsize(init_arsize), .init_arburst(init_arburst), .init_arprot(init_arprot),
    .init_aruser(init_aruser), .init_arvalid(init_arvalid), .init_arready(init_arready),
    .init_rid(init_rid), .init_rdata(init_rdata), .init_ruser(init_ruser),
    .init_rresp(init_rresp), .init_rlast(init_rlast), .init_rvalid(init_rvalid),
    .init_rready(init_rready),
    .target_rid(target_rid), .target_rdata(target_rdata), .target_ruser(target_ruser),
    .target_rresp(target_rresp), .target_rlast(target_rlast), .target_rvalid(target_rvalid),
    .target_rready(target_rready),
    .wr_outstanding(wr_outstanding),
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    .err_unexpected_resp(err_unexpected_resp),
`endif
    .rd_outstanding(rd_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    target_awvalid = 1'b1;
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd0) $display("[TB] FAIL reset_wr: got %0d expected 0", wr_outstanding);
    else passCount++;
    checkCount++;
    if (rd_outstanding !== 3'd0) $display("[TB] FAIL reset_rd: got %0d expected 0", rd_outstanding);
    else passCount++;
    checkCount++;
    if (init_awvalid !== 1'b1) $display("[TB] FAIL reset_awvalid_open: got %b expected 1", init_awvalid);
    else passCount++;
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    checkCount++;
    if (err_unexpected_resp !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err_unexpected_resp);
    else passCount++;
`endif
    target_awvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aw_limit();
    logic [11:0] expAddr;
    @(negedge clk);
    target_awvalid = 1'b1;
    init_awready   = 1'b1;
    target_awlen   = 8'h03;
    for (int i = 0; i < 4; i++) begin
      expAddr = 12'h100 + 12'(i * 16);
      target_awaddr = expAddr;
      #1;
      checkCount++;
      if (init_awaddr !== expAddr || init_awlen !== 8'h03)
        $display("[TB] FAIL aw_payload_%0d: got %h/%h expected %h/03", i, init_awaddr, init_awlen, expAddr);
      else passCount++;
      checkCount++;
      if (init_awvalid !== 1'b1 || target_awready !== 1'b1)
        $display("[TB] FAIL aw_open_%0d: got valid %b ready %b expected 1 1", i, init_awvalid, target_awready);
      else passCount++;
      @(posedge clk);
      #1;
      checkCount++;
      if (wr_outstanding !== 3'(i + 1))
        $display("[TB] FAIL aw_count_%0d: got %0d expected %0d", i, wr_outstanding, i + 1);
      else passCount++;
      @(negedge clk);
    end
    #1;
    checkCount++;
    if (init_awvalid !== 1'b0 || target_awready !== 1'b0)
      $display("[TB] FAIL aw_stall: got valid %b ready %b expected 0 0", init_awvalid, target_awready);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd4) $display("[TB] FAIL aw_full_hold: got %0d expected 4", wr_outstanding);
    else passCount++;
  endtask

  task automatic test_b_release();
    @(negedge clk);
    init_bvalid   = 1'b1;
    target_bready = 1'b1;
    init_bresp    = 2'b10;
    init_bid      = 1'b1;
    #1;
    checkCount++;
    if (target_bvalid !== 1'b1 || target_bresp !== 2'b10 || target_bid !== 1'b1 || init_bready !== 1'b1)
      $display("[TB] FAIL b_passthru: got v%b r%h id%b rdy%b expected v1 r2 id1 rdy1",
               target_bvalid, target_bresp, target_bid, init_bready);
    else passCount++;
    checkCount++;
    if (target_awready !== 1'b0) $display("[TB] FAIL b_same_cycle_aw: got %b expected 0", target_awready);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd3) $display("[TB] FAIL b_dec: got %0d expected 3", wr_outstanding);
    else passCount++;
    @(negedge clk);
    init_bvalid = 1'b0;
    #1;
    checkCount++;
    if (target_awready !== 1'b1 || init_awvalid !== 1'b1)
      $display("[TB] FAIL b_next_cycle_aw: got ready %b valid %b expected 1 1", target_awready, init_awvalid);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd4) $display("[TB] FAIL b_refill: got %0d expected 4", wr_outstanding);
    else passCount++;
    @(negedge clk);
    target_awvalid = 1'b0;
    init_bvalid    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd0) $display("[TB] FAIL b_drain: got %0d expected 0", wr_outstanding);
    else passCount++;
    @(negedge clk);
    init_bvalid = 1'b0;
  endtask

  task automatic test_read();
    logic [31:0] expData;
    @(negedge clk);
    target_arvalid = 1'b1;
    init_arready   = 1'b1;
    target_araddr  = 12'hABC;
    target_arprot  = 3'b101;
    target_rready  = 1'b1;
    #1;
    checkCount++;
    if (init_araddr !== 12'hABC || init_arprot !== 3'b101)
      $display("[TB] FAIL ar_payload: got %h/%b expected abc/101", init_araddr, init_arprot);
    else passCount++;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (rd_outstanding !== 3'd2) $display("[TB] FAIL ar_count: got %0d expected 2", rd_outstanding);
    else passCount++;
    @(negedge clk);
    init_rvalid = 1'b1;
    init_rlast  = 1'b1;
    #1;
    checkCount++;
    if (init_arvalid !== 1'b1 || target_rvalid !== 1'b1 || init_rready !== 1'b1)
      $display("[TB] FAIL ar_r_same: got arv %b rv %b rrdy %b expected 1 1 1",
               init_arvalid, target_rvalid, init_rready);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (rd_outstanding !== 3'd2) $display("[TB] FAIL ar_r_cancel: got %0d expected 2", rd_outstanding);
    else passCount++;
    @(negedge clk);
    target_arvalid = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      expData    = 32'hA000_0000 + 32'(b);
      init_rdata = expData;
      init_rlast = (b == 4);
      #1;
      checkCount++;
      if (target_rdata !== expData || target_rlast !== (b == 4))
        $display("[TB] FAIL r_beat_%0d: got %h last %b expected %h last %b",
                 b, target_rdata, target_rlast, expData, (b == 4));
      else passCount++;
      @(posedge clk);
      #1;
      checkCount++;
      if (rd_outstanding !== ((b == 4) ? 3'd1 : 3'd2))
        $display("[TB] FAIL r_count_%0d: got %0d expected %0d", b, rd_outstanding, (b == 4) ? 1 : 2);
      else passCount++;
      @(negedge clk);
    end
    init_rlast = 1'b1;
    @(posedge clk);
    #1;
    checkCount++;
    if (rd_outstanding !== 3'd0) $display("[TB] FAIL r_drain: got %0d expected 0", rd_outstanding);
    else passCount++;
    @(negedge clk);
    init_rvalid = 1'b0;
    init_rlast  = 1'b0;
  endtask

  task automatic test_unexpected_resp();
    @(negedge clk);
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    checkCount++;
    if (err_unexpected_resp !== 1'b0) $display("[TB] FAIL err_pre: got %b expected 0", err_unexpected_resp);
    else passCount++;
`endif
    init_bvalid   = 1'b1;
    target_bready = 1'b1;
    @(posedge clk);
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd0) $display("[TB] FAIL wr_saturate: got %0d expected 0", wr_outstanding);
    else passCount++;
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    checkCount++;
    if (err_unexpected_resp !== 1'b1) $display("[TB] FAIL err_set: got %b expected 1", err_unexpected_resp);
    else passCount++;
`endif
    @(negedge clk);
    init_bvalid = 1'b0;
    init_rvalid = 1'b1;
    init_rlast  = 1'b1;
    @(posedge clk);
    #1;
    checkCount++;
    if (rd_outstanding !== 3'd0) $display("[TB] FAIL rd_saturate: got %0d expected 0", rd_outstanding);
    else passCount++;
    @(negedge clk);
    init_rvalid = 1'b0;
    init_rlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    checkCount++;
    if (err_unexpected_resp !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", err_unexpected_resp);
    else passCount++;
`endif
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    target_awvalid = 1'b1;
    init_awready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd3) $display("[TB] FAIL arst_pre: got %0d expected 3", wr_outstanding);
    else passCount++;
    @(negedge clk);
    target_awvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd0) $display("[TB] FAIL arst_clear: got %0d expected 0", wr_outstanding);
    else passCount++;
`ifdef BR_AMBA_AXI_OUTSTANDING_LIMITER_ERR_EN
    checkCount++;
    if (err_unexpected_resp !== 1'b0) $display("[TB] FAIL arst_err: got %b expected 0", err_unexpected_resp);
    else passCount++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    target_awvalid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkCount++;
    if (wr_outstanding !== 3'd4) $display("[TB] FAIL arst_refill: got %0d expected 4", wr_outstanding);
    else passCount++;
    checkCount++;
    if (target_awready !== 1'b0) $display("[TB] FAIL arst_full: got %b expected 0", target_awready);
    else passCount++;
  endtask

  task automatic test_w_passthrough();
    @(negedge clk);
    target_wdata  = 32'hDEAD_BEEF;
    target_wstrb  = 4'h5;
    target_wlast  = 1'b1;
    target_wvalid = 1'b1;
    init_wready   = 1'b1;
    #1;
    checkCount++;
    if (init_wdata !== 32'hDEAD_BEEF || init_wstrb !== 4'h5 || init_wlast !== 1'b1 ||
        init_wvalid !== 1'b1 || target_wready !== 1'b1)
      $display("[TB] FAIL w_passthru: got %h/%h/%b/%b/%b expected deadbeef/5/1/1/1",
               init_wdata, init_wstrb, init_wlast, init_wvalid, target_wready);
    else passCount++;
    target_wvalid  = 1'b0;
    target_awvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {target_awaddr, target_awid, target_awlen, target_awsize, target_awburst,
     target_awprot, target_awuser, target_awvalid, init_awready} = '0;
    {target_araddr, target_arid, target_arlen, target_arsize, target_arburst,
     target_arprot, target_aruser, target_arvalid, init_arready} = '0;
    {target_wdata, target_wstrb, target_wuser, target_wlast, target_wvalid, init_wready} = '0;
    {init_bid, init_buser, init_bresp, init_bvalid, target_bready} = '0;
    {init_rid, init_rdata, init_ruser, init_rresp, init_rlast, init_rvalid, target_rready} = '0;

    test_reset();
    test_aw_limit();
    test_b_release();
    test_read();
    test_unexpected_resp();
    test_async_reset();
    test_w_passthrough();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
